// File: rtl/aes_uart_sequencer.sv
// aes_uart_sequencer: collects 16 UART bytes into an AES-128 block, runs the core,
// then streams the ciphertext back MSB byte first through the UART transmitter.
module aes_uart_sequencer #(
  parameter int BLOCK_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic         clockIN,
  input  logic         nResetIN,
  input  logic         rxReadyIN,
  input  logic [7:0]   rxDataIN,
  input  logic         txReadyIN,
  output logic [7:0]   txDataOUT,
  output logic         txLoadOUT,
  output logic [127:0] aesBlockOUT,
  output logic         aesStartOUT,
  input  logic         aesDoneIN,
  input  logic [127:0] aesResultIN,
  output logic         busyOUT,
  output logic         overrunOUT,
  output logic         timeoutOUT
);
  localparam int CW = $clog2(BLOCK_BYTES) + 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FULL = CW'(BLOCK_BYTES);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {COLLECT, START, WAIT_AES, SEND_LOAD, SEND_WAIT} state_e;
  state_e state_q, state_d;
  logic rx_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [127:0] blk_q, blk_d, res_q, res_d;
  logic [7:0] tx_q, tx_d;
  logic ovr_q, ovr_d, tmo_q, tmo_d;
  logic byte_ev, collecting, tmo_fire;
  assign byte_ev    = rxReadyIN & ~rx_q;
  // a full block still sitting in COLLECT is no longer accepting bytes
  assign collecting = state_q == COLLECT && cnt_q != FULL;
  assign tmo_fire   = TIMEOUT_CYCLES != 0 && collecting && cnt_q != '0 && !byte_ev && idle_q == IDLE_LAST;
  always_ff @(posedge clockIN or negedge nResetIN)
    if (!nResetIN) state_q <= COLLECT;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT:   state_d = cnt_q == FULL ? START : COLLECT;
      START:     state_d = WAIT_AES;
      WAIT_AES:  state_d = aesDoneIN ? SEND_LOAD : WAIT_AES;
      SEND_LOAD: state_d = txReadyIN ? SEND_LOAD : SEND_WAIT;
      SEND_WAIT: state_d = !txReadyIN ? SEND_WAIT : cnt_q == LAST ? COLLECT : SEND_LOAD;
      default:   state_d = COLLECT;
    endcase
  end
  always_comb begin
    aesStartOUT = state_q == START;
    txLoadOUT   = state_q == SEND_LOAD;
    busyOUT     = state_q != COLLECT;
  end
  always_comb begin
    cnt_d  = cnt_q;
    idle_d = idle_q;
    blk_d  = blk_q;
    res_d  = res_q;
    tx_d   = tx_q;
    ovr_d  = ovr_q | (byte_ev & ~collecting);
    tmo_d  = tmo_fire;
    if (collecting && byte_ev) begin
      blk_d  = {blk_q[119:0], rxDataIN};
      cnt_d  = cnt_q + 1'b1;
      idle_d = '0;
    end else if (tmo_fire) begin
      cnt_d  = '0;
      idle_d = '0;
    end else if (collecting && cnt_q != '0) idle_d = idle_q + 1'b1;
    if (state_q == WAIT_AES && aesDoneIN) begin
      res_d = aesResultIN;
      tx_d  = aesResultIN[127:120];
      cnt_d = '0;
    end
    // during transmission the counter tracks bytes already handed to the UART
    if (state_q == SEND_WAIT && txReadyIN) begin
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      res_d = cnt_q == LAST ? res_q : res_q << 8;
      tx_d  = cnt_q == LAST ? tx_q : res_q[119:112];
    end
  end
  always_ff @(posedge clockIN or negedge nResetIN)
    if (!nResetIN) begin
      rx_q   <= 1'b0;
      cnt_q  <= '0;
      idle_q <= '0;
      blk_q  <= '0;
      res_q  <= '0;
      tx_q   <= '0;
      ovr_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      rx_q   <= rxReadyIN;
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
      blk_q  <= blk_d;
      res_q  <= res_d;
      tx_q   <= tx_d;
      ovr_q  <= ovr_d;
      tmo_q  <= tmo_d;
    end
  assign txDataOUT   = tx_q;
  assign aesBlockOUT = blk_q;
  assign overrunOUT  = ovr_q;
  assign timeoutOUT  = tmo_q;
endmodule

// File: tb/tb_aes_uart_sequencer.sv
// tb_aes_uart_sequencer: random UART/AES traffic checked against a transaction-level
// model (expected blocks and ciphertext byte queues) plus per-cycle handshake rules.
`timescale 1ns/1ps
module tb_aes_uart_sequencer;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clockIN = 0, nResetIN = 0, rxReadyIN = 0, txReadyIN = 1, aesDoneIN = 0;
  logic [7:0] rxDataIN = 0;
  logic [127:0] aesResultIN = 0;
  logic [7:0] txDataOUT;
  logic txLoadOUT, aesStartOUT, busyOUT, overrunOUT, timeoutOUT;
  logic [127:0] aesBlockOUT;
  int checks = 0, errors = 0;
  int nstart = 0, nload = 0, ntmo = 0;
  int aes_lat = 11, early = 0, fix_tx = 1;
  logic [127:0] exp_blk[$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[512];
  logic [127:0] aes_in, aes_ct;
  logic p_load = 0, p_ready = 1, p_start = 0, p_tmo = 0;
  logic [7:0] p_data = 0;

  aes_uart_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clockIN(clockIN), .nResetIN(nResetIN), .rxReadyIN(rxReadyIN), .rxDataIN(rxDataIN),
    .txReadyIN(txReadyIN), .txDataOUT(txDataOUT), .txLoadOUT(txLoadOUT),
    .aesBlockOUT(aesBlockOUT), .aesStartOUT(aesStartOUT), .aesDoneIN(aesDoneIN),
    .aesResultIN(aesResultIN), .busyOUT(busyOUT), .overrunOUT(overrunOUT), .timeoutOUT(timeoutOUT)
  );

  always #5 clockIN = ~clockIN;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Stand-in for the AES core: exact for the FIPS-197 vector, an arbitrary bijection otherwise.
  function automatic logic [127:0] cipher(input logic [127:0] p);
    return p == FIPS_PT ? FIPS_CT : {p[63:0] ^ 64'h0f1e2d3c4b5a6978, ~p[127:64]};
  endfunction

  always @(negedge clockIN) begin
    if (nResetIN) begin
      if (txLoadOUT && !p_load) begin
        if (exp_tx.size() == 0) check("tx_unexpected_load", 1, 0);
        else check("tx_byte", txDataOUT, exp_tx.pop_front());
        got_tx[nload] = txDataOUT;
        nload++;
      end else check("tx_data_stable", txDataOUT, p_data);
      if (p_load) check("tx_load_fall", txLoadOUT, p_ready);
      if (aesStartOUT) begin
        nstart++;
        check("start_width", p_start, 0);
      end
      if (txLoadOUT | aesStartOUT) check("busy_in_op", busyOUT, 1);
      if (timeoutOUT) begin
        ntmo++;
        check("timeout_width", p_tmo, 0);
      end
    end
    p_load = txLoadOUT;
    p_ready = txReadyIN;
    p_start = aesStartOUT;
    p_tmo = timeoutOUT;
    p_data = txDataOUT;
  end

  initial forever begin
    @(negedge clockIN);
    if (nResetIN && aesStartOUT) begin
      aes_in = aesBlockOUT;
      if (exp_blk.size() == 0) check("aes_unexpected_start", 1, 0);
      else check("aes_block", aes_in, exp_blk.pop_front());
      if (early != 0) begin
        aesDoneIN = 1;
        aesResultIN = {4{$urandom}};
      end
      @(posedge clockIN);
      #1 aesDoneIN = 0;
      repeat (aes_lat - 1) @(posedge clockIN);
      aes_ct = cipher(aes_in);
      #1 aesDoneIN = 1;
      aesResultIN = aes_ct;
      for (int i = 15; i >= 0; i--) exp_tx.push_back(aes_ct[i*8 +: 8]);
      repeat ($urandom_range(1, 3)) @(posedge clockIN);
      #1 aesDoneIN = 0;
      aesResultIN = {4{$urandom}};
    end
  end

  initial forever begin
    @(negedge clockIN);
    if (nResetIN && txLoadOUT && txReadyIN) begin
      repeat (fix_tx != 0 ? 3 : $urandom_range(1, 4)) @(posedge clockIN);
      #1 txReadyIN = 0;
      repeat (fix_tx != 0 ? 20 : $urandom_range(1, 12)) @(posedge clockIN);
      #1 txReadyIN = 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clockIN);
    #1 rxDataIN = b;
    rxReadyIN = 1;
    repeat (2) @(posedge clockIN);
    #1 rxReadyIN = 0;
    repeat ($urandom_range(1, 5)) @(posedge clockIN);
  endtask

  task automatic send_block(input logic [127:0] pt);
    exp_blk.push_back(pt);
    for (int i = 15; i >= 0; i--) send_byte(pt[i*8 +: 8]);
  endtask

  task automatic finish_block(input int base);
    int n = 0;
    while (!(nload - base >= 16 && !busyOUT) && n < 4000) begin
      @(negedge clockIN);
      #1 n++;
    end
    check("block_done_in_time", n < 4000, 1);
    check("load_count", nload - base, 16);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("blk_queue_drained", exp_blk.size(), 0);
    check("idle_after_block", busyOUT, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] pt, ct;
    int base, s, n, t0;
    repeat (3) @(posedge clockIN);
    @(negedge clockIN);
    check("rst_txData", txDataOUT, 0);
    check("rst_txLoad", txLoadOUT, 0);
    check("rst_block", aesBlockOUT, 0);
    check("rst_start", aesStartOUT, 0);
    check("rst_busy", busyOUT, 0);
    check("rst_overrun", overrunOUT, 0);
    check("rst_timeout", timeoutOUT, 0);
    @(posedge clockIN);
    #1 nResetIN = 1;

    base = nload;
    send_block(FIPS_PT);
    finish_block(base);
    ct = '0;
    for (int i = 0; i < 16; i++) ct = {ct[119:0], got_tx[base + i]};
    check("fips_ciphertext", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("fips_first_byte", got_tx[base], 8'h69);
    check("fips_last_byte", got_tx[base + 15], 8'h5a);
    check("fips_one_start", nstart, 1);
    check("no_overrun_yet", overrunOUT, 0);

    fix_tx = 0;
    repeat (2) begin
      aes_lat = $urandom_range(1, 30);
      base = nload;
      send_block(rnd128());
      finish_block(base);
    end
    check("no_timeout_normal", ntmo, 0);

    pt = rnd128();
    for (int i = 15; i >= 11; i--) send_byte(pt[i*8 +: 8]);
    @(negedge clockIN);
    check("partial_block", aesBlockOUT[39:0], pt[127:88]);
    t0 = ntmo;
    repeat (50) @(negedge clockIN);
    #1 check("timeout_not_early", ntmo - t0, 0);
    repeat (80) @(negedge clockIN);
    #1 check("timeout_once", ntmo - t0, 1);
    check("timeout_not_busy", busyOUT, 0);
    base = nload;
    send_block(rnd128());
    finish_block(base);

    aes_lat = 40;
    s = nstart;
    base = nload;
    send_block(rnd128());
    n = 0;
    while (nstart == s && n < 200) begin
      @(negedge clockIN);
      #1 n++;
    end
    check("start_seen", nstart - s, 1);
    send_byte(8'($urandom));
    @(negedge clockIN);
    check("overrun_set", overrunOUT, 1);
    finish_block(base);
    check("overrun_sticky", overrunOUT, 1);
    aes_lat = $urandom_range(1, 20);
    base = nload;
    send_block(rnd128());
    finish_block(base);
    check("overrun_still_sticky", overrunOUT, 1);

    early = 1;
    aes_lat = $urandom_range(2, 12);
    base = nload;
    send_block(rnd128());
    finish_block(base);
    early = 0;

    aes_lat = 5;
    base = nload;
    send_block(rnd128());
    n = 0;
    while (nload - base < 8 && n < 2000) begin
      @(negedge clockIN);
      #1 n++;
    end
    check("eighth_load_seen", nload - base, 8);
    #1 nResetIN = 0;
    #1 check("async_rst_txLoad", txLoadOUT, 0);
    check("async_rst_busy", busyOUT, 0);
    check("async_rst_overrun", overrunOUT, 0);
    check("async_rst_block", aesBlockOUT, 0);
    exp_tx.delete();
    exp_blk.delete();
    @(negedge clockIN);
    @(posedge clockIN);
    #1 nResetIN = 1;
    aes_lat = $urandom_range(1, 20);
    base = nload;
    send_block(rnd128());
    finish_block(base);
    check("overrun_clear_after_rst", overrunOUT, 0);
    check("timeout_total", ntmo, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule
